fadd_single_seq: RTL

Multi-cycle IEEE-754 single-precision add/subtract unit with valid/ready handshakes on both sides. It is the registered, handshaked counterpart to the combinational subtractor: one operand pair accepted, a fixed 5-cycle computation, one result presented and held until consumed. It sits between an operand source (register file or test driver) and a result sink, and serves both `a+b` and `a-b` through `op_sub`.

---
 rtl/fp32_pkg.sv | 11 +
 rtl/fp_lzc27.sv | 13 +
 rtl/fadd_single_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/fp32_pkg.sv
// fp32_pkg: binary32 field widths, special encodings and add-unit state encoding
package fp32_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS = 127;
  localparam int SIG_W = 27;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] NEG_INF = 32'hFF800000;
  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;
endpackage

// File: rtl/fp_lzc27.sv
// fp_lzc27: leading-zero count of a 27-bit extended significand
import fp32_pkg::*;
module fp_lzc27 (
  input  logic [SIG_W-1:0] x,
  output logic [4:0]       cnt,
  output logic             zero
);
  always_comb begin
    cnt = 5'd0;
    for (int i = 0; i < SIG_W; i++) if (x[i]) cnt = 5'(SIG_W - 1 - i);
  end
  assign zero = ~|x;
endmodule

// File: rtl/fadd_single_seq.sv
// fadd_single_seq: multi-cycle binary32 add/subtract, fixed 5-cycle latency, valid/ready on both sides
import fp32_pkg::*;
module fadd_single_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  flags
);
  state_t state;
  logic [31:0] ra, rb;
  logic sx, sy, nan, inv, inf, inf_s, zero, uf;
  logic [9:0] e;
  logic [7:0] d;
  logic [23:0] mx;
  logic [SIG_W:0] sig;
  assign in_ready = (state == IDLE) && !rst;
  // Operands with a zero exponent are flushed before the magnitude compare
  logic [30:0] ma, mb, bx, by;
  logic swap, a_nan, b_nan, a_inf, b_inf;
  assign ma = ~|ra[30:23] ? 31'd0 : ra[30:0];
  assign mb = ~|rb[30:23] ? 31'd0 : rb[30:0];
  assign swap = mb > ma;
  assign bx = swap ? mb : ma;
  assign by = swap ? ma : mb;
  assign a_nan = &ra[30:23] & |ra[22:0];
  assign b_nan = &rb[30:23] & |rb[22:0];
  assign a_inf = &ra[30:23] & ~|ra[22:0];
  assign b_inf = &rb[30:23] & ~|rb[22:0];
  logic [53:0] wide;
  logic [SIG_W:0] aligned;
  assign wide = {sig[SIG_W-1:0], 27'd0} >> d;
  assign aligned = d >= 8'd27 ? {27'd0, |sig[SIG_W-1:0]} : {1'b0, wide[53:28], wide[27] | |wide[26:0]};
  logic [4:0] lz;
  logic lz_zero;
  fp_lzc27 u_lzc (.x(sig[SIG_W-1:0]), .cnt(lz), .zero(lz_zero));
  // Round to nearest even on guard/round/sticky; a mantissa carry bumps the exponent
  logic up, ovf, inexact;
  logic [24:0] m25;
  logic [9:0] e_r;
  logic [31:0] res_n;
  logic [2:0] flg_n;
  assign up = sig[2] & (sig[1] | sig[0] | sig[3]);
  assign m25 = {1'b0, sig[26:3]} + {24'd0, up};
  assign e_r = e + {9'd0, m25[24]};
  assign ovf = e_r >= 10'd255;
  assign inexact = |sig[2:0];
  assign res_n = (nan | inv) ? QNAN : inf ? {inf_s, POS_INF[30:0]} : (zero | uf) ? {sx, 31'd0} :
                 ovf ? {sx, POS_INF[30:0]} : {sx, e_r[7:0], m25[22:0]};
  assign flg_n = (nan | inv) ? {inv, 2'b00} : inf ? 3'b000 : (zero | uf) ? {2'b00, uf} :
                 ovf ? 3'b011 : {2'b00, inexact};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      result <= 32'd0;
      flags <= 3'b000;
    end else begin
      case (state)
        IDLE: if (in_valid) state <= UNPACK;
        UNPACK: state <= ALIGN;
        ALIGN: state <= ADD;
        ADD: state <= NORM;
        NORM: state <= ROUND;
        ROUND: begin
          state <= DONE;
          out_valid <= 1'b1;
          result <= res_n;
          flags <= flg_n;
        end
        default: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (in_valid) begin
        ra <= a;
        rb <= {b[31] ^ op_sub, b[30:0]};
      end
      UNPACK: begin
        sx <= swap ? rb[31] : ra[31];
        sy <= swap ? ra[31] : rb[31];
        e <= {2'b00, bx[30:23]};
        d <= bx[30:23] - by[30:23];
        mx <= {|bx[30:23], bx[22:0]};
        sig <= {1'b0, |by[30:23], by[22:0], 3'b000};
        nan <= a_nan | b_nan;
        inv <= a_inf & b_inf & (ra[31] ^ rb[31]);
        inf <= a_inf | b_inf;
        inf_s <= a_inf ? ra[31] : rb[31];
      end
      ALIGN: sig <= aligned;
      ADD: sig <= (sx ^ sy) ? {1'b0, mx, 3'b000} - sig : {1'b0, mx, 3'b000} + sig;
      NORM: begin
        zero <= lz_zero & ~sig[SIG_W];
        uf <= ~sig[SIG_W] & ~lz_zero & (e <= {5'd0, lz});
        sx <= (lz_zero & ~sig[SIG_W]) ? sx & sy : sx;
        sig <= sig[SIG_W] ? {1'b0, sig[SIG_W:2], |sig[1:0]} : sig << lz;
        e <= sig[SIG_W] ? e + 10'd1 : e - {5'd0, lz};
      end
      default: ;
    endcase
  end
endmodule
